// File: rtl/a_cap_pkg.sv
// Shared widths and the captured word layout for the a_cap capture FIFO.
package a_cap_pkg;

    localparam int D_W   = 3;
    localparam int E_W   = 2;
    localparam int F_W   = 2;
    localparam int CAP_W = 7;

    typedef struct packed {
        logic [D_W-1:0] d;
        logic [E_W-1:0] e;
        logic [F_W-1:0] f;
    } cap_word_t;

endpackage

// File: rtl/a_cap_ram.sv
// DEPTH x W storage: one synchronous write port and one asynchronous read port.
module a_cap_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 7,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; empty/valid already mask stale contents, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/a_cap_fifo.sv
// Capture FIFO for module a outputs: c strobes {d,e,f} into a show-ahead queue with sticky overflow.
// Optional macro A_CAP_FIFO_OVF_CNT_EN adds a saturating dropped-word counter ovf_cnt.
module a_cap_fifo
    import a_cap_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c,
    input  logic [D_W-1:0]   d,
    input  logic [E_W-1:0]   e,
    input  logic [F_W-1:0]   f,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [CAP_W-1:0] q_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level,
    output logic             ovf,
    input  logic             ovf_clr
`ifdef A_CAP_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]       ovf_cnt
`endif
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    cap_word_t     wr_word;
    logic          push;
    logic          pop;
    logic          drop;

    assign wr_word = {d, e, f};

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign q_valid = !empty;

    // A pop frees the slot the same edge, so a full FIFO still accepts a concurrent push.
    assign pop  = q_valid && q_ready;
    assign push = c && (!full || pop);
    assign drop = c && full && !pop;

    a_cap_ram #(
        .DEPTH (DEPTH),
        .W     (CAP_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .raddr (rd_ptr),
        .rdata (q_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef A_CAP_FIFO_OVF_CNT_EN
    // A drop coinciding with a clear restarts the count at one rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (drop) begin
            if (ovf_clr)               ovf_cnt <= 8'd1;
            else if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_a_cap_fifo.sv
// Self-checking bench for a_cap_fifo: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_a_cap_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       c = 1'b0;
    logic [2:0] d = '0;
    logic [1:0] e = '0;
    logic [1:0] f = '0;
    logic       q_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       q_valid;
    logic [6:0] q_data;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic       ovf;
`ifdef A_CAP_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    a_cap_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .q_data  (q_data),
        .empty   (empty),
        .full    (full),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`ifdef A_CAP_FIFO_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a plain queue of words plus the overflow flag and drop count.
    logic [6:0] mq[$];
    logic       m_ovf = 1'b0;
    int         m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf <= 1'b0;
            m_cnt <= 0;
        end else begin : model_step
            int  sz;
            bit  pp;
            bit  dropped;
            sz      = mq.size();
            pp      = (sz > 0) && q_ready;
            dropped = c && (sz == DEPTH) && !pp;
            if (pp) void'(mq.pop_front());
            if (c && !dropped) mq.push_back({d, e, f});
            if (dropped)      m_ovf <= 1'b1;
            else if (ovf_clr) m_ovf <= 1'b0;
            if (dropped)      m_cnt <= ovf_clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
            else if (ovf_clr) m_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("level",   32'(level),   32'(mq.size()));
            check("empty",   32'(empty),   32'(mq.size() == 0));
            check("full",    32'(full),    32'(mq.size() == DEPTH));
            check("q_valid", 32'(q_valid), 32'(mq.size() != 0));
            check("ovf",     32'(ovf),     32'(m_ovf));
            if (mq.size() != 0) check("q_data", 32'(q_data), 32'(mq[0]));
`ifdef A_CAP_FIFO_OVF_CNT_EN
            check("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic cyc(input bit ci, input logic [6:0] w, input bit rdy, input bit clr);
        @(negedge clk);
        c         = ci;
        {d, e, f} = w;
        q_ready   = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        c = 1'b0; q_ready = 1'b0; ovf_clr = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic fill4();
        cyc(1'b1, 7'h11, 1'b0, 1'b0);
        cyc(1'b1, 7'h22, 1'b0, 1'b0);
        cyc(1'b1, 7'h33, 1'b0, 1'b0);
        cyc(1'b1, 7'h44, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0] exp4 [4];
        exp4[0] = 7'h11; exp4[1] = 7'h22; exp4[2] = 7'h33; exp4[3] = 7'h44;

        #1;
        check("rst_q_valid", 32'(q_valid), 32'd0);
        check("rst_empty",   32'(empty),   32'd1);
        check("rst_full",    32'(full),    32'd0);
        check("rst_level",   32'(level),   32'd0);
        check("rst_ovf",     32'(ovf),     32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // 1: single push lands on the output after one edge
        cyc(1'b1, {3'b101, 2'b10, 2'b01}, 1'b0, 1'b0);
        check("t1_q_valid", 32'(q_valid), 32'd1);
        check("t1_q_data",  32'(q_data),  32'h59);
        check("t1_level",   32'(level),   32'd1);
        check("t1_empty",   32'(empty),   32'd0);
        do_reset();

        // 2: fill then drain in order
        fill4();
        check("t2_full",  32'(full),  32'd1);
        check("t2_level", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_order", 32'(q_data), 32'(exp4[i]));
            cyc(1'b0, 7'h00, 1'b1, 1'b0);
        end
        check("t2_empty",   32'(empty),   32'd1);
        check("t2_q_valid", 32'(q_valid), 32'd0);

        // q_ready while empty must be ignored
        cyc(1'b0, 7'h00, 1'b1, 1'b0);
        check("t2_underflow_level", 32'(level), 32'd0);

        // 3: overflow drops the word, sticky flag, then clear
        fill4();
        cyc(1'b1, 7'h55, 1'b0, 1'b0);
        check("t3_ovf",   32'(ovf),   32'd1);
        check("t3_level", 32'(level), 32'd4);
        cyc(1'b0, 7'h00, 1'b0, 1'b0);
        check("t3_hold_data", 32'(q_data), 32'h11);
        for (int i = 0; i < 4; i++) begin
            check("t3_order", 32'(q_data), 32'(exp4[i]));
            cyc(1'b0, 7'h00, 1'b1, 1'b0);
        end
        check("t3_empty", 32'(empty), 32'd1);
        check("t3_ovf_sticky", 32'(ovf), 32'd1);
        cyc(1'b0, 7'h00, 1'b0, 1'b1);
        check("t3_ovf_clr", 32'(ovf), 32'd0);

        // 4: push and pop together while full
        fill4();
        cyc(1'b1, 7'h66, 1'b1, 1'b0);
        check("t4_ovf",   32'(ovf),    32'd0);
        check("t4_level", 32'(level),  32'd4);
        check("t4_head",  32'(q_data), 32'h22);
        exp4[0] = 7'h22; exp4[1] = 7'h33; exp4[2] = 7'h44; exp4[3] = 7'h66;
        for (int i = 0; i < 4; i++) begin
            check("t4_order", 32'(q_data), 32'(exp4[i]));
            cyc(1'b0, 7'h00, 1'b1, 1'b0);
        end
        check("t4_empty", 32'(empty), 32'd1);

        // 5: asynchronous reset between edges
        cyc(1'b1, 7'h11, 1'b0, 1'b0);
        cyc(1'b1, 7'h22, 1'b0, 1'b0);
        c = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_q_valid", 32'(q_valid), 32'd0);
        check("t5_level",   32'(level),   32'd0);
        check("t5_full",    32'(full),    32'd0);
        check("t5_empty",   32'(empty),   32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;

`ifdef A_CAP_FIFO_OVF_CNT_EN
        // 6: counter saturation and drop-with-clear
        fill4();
        repeat (300) cyc(1'b1, 7'($urandom), 1'b0, 1'b0);
        check("t6_cnt_sat", 32'(ovf_cnt), 32'hFF);
        cyc(1'b1, 7'h7F, 1'b0, 1'b1);
        check("t6_cnt_one", 32'(ovf_cnt), 32'd1);
        check("t6_ovf",     32'(ovf),     32'd1);
        cyc(1'b0, 7'h00, 1'b0, 1'b1);
        check("t6_cnt_clr", 32'(ovf_cnt), 32'd0);
        do_reset();
`endif

        // Random phases with varying push/pop pressure
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 800; n++) begin
                cyc($urandom_range(0, 99) < (70 - ph * 20),
                    7'($urandom),
                    $urandom_range(0, 99) < (30 + ph * 25),
                    $urandom_range(0, 99) < 5);
            end
            if (ph == 1) do_reset();
        end

        c = 1'b0; q_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
